// File: rtl/ysyx_25040111_axi_pkg.sv
// Shared AXI4 constants and bridge state encoding
// for the icache refill bridge.
package ysyx_25040111_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_BEAT,
        ST_HOLD
    } bridge_state_t;

endpackage

// File: rtl/ysyx_25040111_icache_axi.sv
// Read-only AXI4 master bridge below the icache:
// turns refill requests into AR/R traffic, one beat at a time.
module ysyx_25040111_icache_axi
    import ysyx_25040111_axi_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            chvalid,
    input  logic [31:0]     chaddr,
    input  logic [7:0]      chlen,
    input  logic            chburst,
    output logic            chready,
    output logic [31:0]     chdata,
    output logic            cherr,
    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [ID_W-1:0] arid,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic [ID_W-1:0] rid
);

    bridge_state_t state;
    logic [8:0]    cnt;
    logic [7:0]    total;
    logic          mode;
    logic          relatch;
    logic [31:0]   araddr_q;
    logic          last_beat;
    logic          unused_rid;

    assign last_beat  = (cnt == {1'b0, total});
    assign unused_rid = ^rid;

    // On the first AR cycle of a follow-on single read the cache
    // has just advanced chaddr, so present it directly.
    assign araddr  = relatch ? chaddr : araddr_q;
    assign arid    = AXI_ID;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    // Bridge FSM with registered handshake and data outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            total    <= '0;
            mode     <= 1'b0;
            relatch  <= 1'b0;
            araddr_q <= '0;
            arlen    <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            chready  <= 1'b0;
            cherr    <= 1'b0;
            chdata   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (chvalid) begin
                        araddr_q <= chaddr;
                        arlen    <= chburst ? chlen : 8'd0;
                        total    <= chlen;
                        mode     <= chburst;
                        cnt      <= '0;
                        arvalid  <= 1'b1;
                        state    <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (relatch) begin
                        araddr_q <= chaddr;
                        relatch  <= 1'b0;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        chdata  <= rdata;
                        cherr   <= (rresp != AXI_RESP_OKAY)
                                 | (mode & (rlast != last_beat));
                        rready  <= 1'b0;
                        chready <= 1'b1;
                        state   <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    chready <= 1'b0;
                    cherr   <= 1'b0;
                    cnt     <= cnt + 9'd1;
                    if (last_beat) begin
                        state <= ST_HOLD;
                    end else if (mode) begin
                        rready <= 1'b1;
                        state  <= ST_R;
                    end else begin
                        arvalid <= 1'b1;
                        relatch <= 1'b1;
                        state   <= ST_AR;
                    end
                end
                ST_HOLD: begin
                    if (!chvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_icache_axi.sv
// Directed bench for the icache AXI bridge: cache and slave
// models drive the DUT, a request-level model predicts AR/beats.
module tb_ysyx_25040111_icache_axi;

    logic        clock;
    logic        reset;
    logic        chvalid;
    logic [31:0] chaddr;
    logic [7:0]  chlen;
    logic        chburst;
    logic        chready;
    logic [31:0] chdata;
    logic        cherr;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    ysyx_25040111_icache_axi dut (
        .clock(clock), .reset(reset),
        .chvalid(chvalid), .chaddr(chaddr),
        .chlen(chlen), .chburst(chburst),
        .chready(chready), .chdata(chdata), .cherr(cherr),
        .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beats[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] data_tab [0:255];
    int ar_delay = 0;
    int r_gap    = 0;
    int err_idx  = -1;
    int last_idx = 0;
    int req_id   = 0;

    int          ar_count   = 0;
    int          beat_count = 0;
    int          err_pulses = 0;
    logic [31:0] last_ar    = '0;
    logic [31:0] last_data  = '0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    // AXI slave: one AR, then arlen+1 R beats; aborts on reset.
    int sk = 0;
    int last_req = -1;
    task automatic slave_txn();
        int n;
        while (!arvalid) begin
            @(negedge clock);
            if (!reset) return;
        end
        repeat (ar_delay) begin
            @(negedge clock);
            if (!reset) return;
        end
        n = int'(arlen) + 1;
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        if (!reset) return;
        if (req_id != last_req) begin
            last_req = req_id;
            sk = 0;
        end
        for (int i = 0; i < n; i++) begin
            repeat (r_gap) begin
                @(negedge clock);
                if (!reset) return;
            end
            rvalid = 1'b1;
            rdata  = data_tab[sk];
            rresp  = (sk == err_idx) ? 2'b10 : 2'b00;
            rlast  = chburst ? (sk == last_idx) : 1'b1;
            while (!rready) begin
                @(negedge clock);
                if (!reset) begin
                    rvalid = 1'b0;
                    return;
                end
            end
            @(negedge clock);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            sk++;
            if (!reset) return;
        end
    endtask

    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rid     = '0;
        forever begin
            @(negedge clock);
            if (reset) slave_txn();
        end
    end

    // Per-cycle checker against the request-level expectations.
    logic        p_wait_ar = 1'b0;
    logic [31:0] p_addr    = '0;
    logic [7:0]  p_len     = '0;
    logic        p_rhs     = 1'b0;
    logic        p_chr     = 1'b0;
    always @(negedge clock) begin
        #1;
        if (!reset) begin
            p_wait_ar = 1'b0;
            p_rhs     = 1'b0;
            p_chr     = 1'b0;
        end else begin
            chk("rready_vs_arvalid", rready & arvalid, 0);
            chk("cherr_needs_chready", cherr & ~chready, 0);
            if (p_wait_ar) begin
                chk("arvalid_held", arvalid, 1);
                chk("araddr_stable", araddr, p_addr);
                chk("arlen_stable", arlen, p_len);
            end
            if (p_rhs) chk("chready_latency", chready, 1);
            if (p_chr) chk("chready_one_cycle", chready, 0);
            if (arvalid && arready) begin
                ar_count++;
                last_ar = araddr;
                chk("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) begin
                    chk("araddr", araddr, exp_ar[0].addr);
                    chk("arlen", arlen, exp_ar[0].len);
                    void'(exp_ar.pop_front());
                end
                chk("arsize", arsize, 3'b010);
                chk("arburst", arburst, 2'b01);
                chk("arid", arid, 4'd0);
            end
            if (chready) begin
                beat_count++;
                last_data = chdata;
                if (cherr) err_pulses++;
                chk("beat_expected", exp_beats.size() != 0, 1);
                if (exp_beats.size() != 0) begin
                    chk("chdata", chdata, exp_beats[0].data);
                    chk("cherr", cherr, exp_beats[0].err);
                    void'(exp_beats.pop_front());
                end
            end
            p_wait_ar = arvalid & ~arready;
            p_addr    = araddr;
            p_len     = arlen;
            p_rhs     = rvalid & rready;
            p_chr     = chready;
        end
    end

    // Cache model plus expectation builder for one refill.
    task automatic run_req(input logic [31:0] a,
                           input logic [7:0]  l,
                           input logic        b);
        int seen;
        int cyc;
        int nb;
        beat_t bt;
        ar_t   ar;
        nb = int'(l) + 1;
        req_id++;
        if (b) begin
            ar.addr = a;
            ar.len  = l;
            exp_ar.push_back(ar);
        end else begin
            for (int k = 0; k < nb; k++) begin
                ar.addr = a + 32'(4 * k);
                ar.len  = 8'd0;
                exp_ar.push_back(ar);
            end
        end
        for (int k = 0; k < nb; k++) begin
            bt.data = data_tab[k];
            bt.err  = (k == err_idx)
                    | (b & ((k == last_idx) != (k == int'(l))));
            exp_beats.push_back(bt);
        end
        @(negedge clock);
        chaddr  = a;
        chlen   = l;
        chburst = b;
        chvalid = 1'b1;
        @(negedge clock);
        chk("arvalid_latency", arvalid, 1);
        seen = 0;
        cyc  = 0;
        while (seen < nb && cyc < 2000) begin
            if (chready) begin
                seen++;
                if (!b && seen < nb) begin
                    @(posedge clock);
                    #1 chaddr = chaddr + 32'd4;
                end
            end
            if (seen < nb) begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("beats_delivered", seen, nb);
        @(negedge clock);
        chvalid = 1'b0;
        repeat (5) @(negedge clock);
        chk("ar_queue_drained", exp_ar.size(), 0);
        chk("beat_queue_drained", exp_beats.size(), 0);
        exp_ar.delete();
        exp_beats.delete();
    endtask

    int a0, b0, e0, cyc;

    initial begin
        reset   = 1'b0;
        chvalid = 1'b0;
        chaddr  = '0;
        chlen   = '0;
        chburst = 1'b0;
        for (int i = 0; i < 256; i++) data_tab[i] = 32'hDEAD_0000 + i;
        repeat (3) @(negedge clock);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_chready", chready, 0);
        chk("rst_cherr", cherr, 0);
        chk("rst_chdata", chdata, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // single non-burst read
        data_tab[0] = 32'h0000_0413;
        a0 = ar_count; b0 = beat_count;
        run_req(32'h8000_0000, 8'd0, 1'b0);
        chk("t1_ar_count", ar_count - a0, 1);
        chk("t1_araddr", last_ar, 32'h8000_0000);
        chk("t1_beats", beat_count - b0, 1);
        chk("t1_data", last_data, 32'h0000_0413);

        // four single reads following the cache address
        for (int i = 0; i < 4; i++) data_tab[i] = 32'hA0 + i;
        a0 = ar_count; b0 = beat_count;
        run_req(32'h3000_0010, 8'd3, 1'b0);
        chk("t2_ar_count", ar_count - a0, 4);
        chk("t2_last_araddr", last_ar, 32'h3000_001C);
        chk("t2_beats", beat_count - b0, 4);
        chk("t2_last_data", last_data, 32'h0000_00A3);

        // INCR burst of four
        data_tab[0] = 32'h11; data_tab[1] = 32'h22;
        data_tab[2] = 32'h33; data_tab[3] = 32'h44;
        last_idx = 3;
        a0 = ar_count; b0 = beat_count; e0 = err_pulses;
        run_req(32'hA000_0000, 8'd3, 1'b1);
        chk("t3_ar_count", ar_count - a0, 1);
        chk("t3_araddr", last_ar, 32'hA000_0000);
        chk("t3_beats", beat_count - b0, 4);
        chk("t3_no_err", err_pulses - e0, 0);
        chk("t3_last_data", last_data, 32'h44);

        // burst with slow AR and gapped R
        ar_delay = 5; r_gap = 2;
        a0 = ar_count; b0 = beat_count;
        run_req(32'hA000_0100, 8'd3, 1'b1);
        chk("t4_ar_count", ar_count - a0, 1);
        chk("t4_beats", beat_count - b0, 4);
        ar_delay = 0; r_gap = 0;

        // error response on beat 2
        err_idx = 1;
        b0 = beat_count; e0 = err_pulses;
        run_req(32'hA000_0200, 8'd3, 1'b1);
        chk("t5a_beats", beat_count - b0, 4);
        chk("t5a_err_pulses", err_pulses - e0, 1);
        err_idx = -1;

        // early rlast on beat 3: beats 3 and 4 flagged
        last_idx = 2;
        b0 = beat_count; e0 = err_pulses;
        run_req(32'hA000_0300, 8'd3, 1'b1);
        chk("t5b_beats", beat_count - b0, 4);
        chk("t5b_err_pulses", err_pulses - e0, 2);
        last_idx = 3;

        // async reset while waiting in R
        r_gap = 10;
        req_id++;
        exp_ar.push_back('{addr: 32'hB000_0000, len: 8'd3});
        @(negedge clock);
        chaddr = 32'hB000_0000; chlen = 8'd3;
        chburst = 1'b1; chvalid = 1'b1;
        cyc = 0;
        while (!rready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("t6_reached_r", rready, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_arvalid", arvalid, 0);
        chk("t6_rready", rready, 0);
        chk("t6_chready", chready, 0);
        chk("t6_araddr", araddr, 0);
        chvalid = 1'b0;
        exp_ar.delete();
        exp_beats.delete();
        r_gap = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("t6_idle_arvalid", arvalid, 0);
        data_tab[0] = 32'h5555_0001;
        data_tab[1] = 32'h5555_0002;
        a0 = ar_count; b0 = beat_count;
        run_req(32'h8000_0040, 8'd1, 1'b0);
        chk("t6_ar_count", ar_count - a0, 2);
        chk("t6_last_araddr", last_ar, 32'h8000_0044);
        chk("t6_last_data", last_data, 32'h5555_0002);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
